// File: rtl/freq_step_sequencer.sv
// Step sequencer: plays up to DEPTH (code, duration) slots through an external
// code-to-period translator and turns the returned half-period into a square wave.
module freq_step_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DUR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [3:0]       wr_code,
    input  logic [DUR_W-1:0] wr_dur,
    input  logic [AW-1:0]    last_step,
    input  logic             loop,
    input  logic             start,
    input  logic             stop,
    input  logic             tick_en,
    input  logic [10:0]      period_in,
    output logic [3:0]       code_out,
    output logic             wave,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    step_idx
);

    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, PLAY, NEXT} state_t;

    state_t             state_q, state_d;
    logic [3:0]         code_mem_q [DEPTH];
    logic [3:0]         code_mem_d [DEPTH];
    logic [DUR_W-1:0]   dur_mem_q  [DEPTH];
    logic [DUR_W-1:0]   dur_mem_d  [DEPTH];
    logic [AW-1:0]      step_idx_q, step_idx_d;
    logic [AW-1:0]      last_q, last_d;
    logic [3:0]         code_q, code_d;
    logic               wave_q, wave_d;
    logic               done_q, done_d;
    logic [DUR_W-1:0]   dur_cnt_q, dur_cnt_d;
    logic [10:0]        per_cnt_q, per_cnt_d;

    always_comb begin
        state_d    = state_q;
        code_mem_d = code_mem_q;
        dur_mem_d  = dur_mem_q;
        step_idx_d = step_idx_q;
        last_d     = last_q;
        code_d     = code_q;
        wave_d     = wave_q;
        done_d     = 1'b0;
        dur_cnt_d  = dur_cnt_q;
        per_cnt_d  = per_cnt_q;

        case (state_q)
            IDLE: begin
                if (wr_en) begin
                    code_mem_d[wr_addr] = wr_code;
                    dur_mem_d[wr_addr]  = wr_dur;
                end
                if (start && !stop) begin
                    state_d    = LOAD;
                    step_idx_d = '0;
                    last_d     = last_step;
                end
            end
            LOAD: begin
                code_d  = code_mem_q[step_idx_q];
                state_d = SETTLE;
            end
            SETTLE: begin
                dur_cnt_d = dur_mem_q[step_idx_q];
                per_cnt_d = '0;
                state_d   = PLAY;
            end
            PLAY: begin
                // A zero-duration slot is skipped without touching the wave phase
                if (dur_cnt_q == '0) begin
                    state_d = NEXT;
                end else begin
                    if (per_cnt_q == period_in) begin
                        per_cnt_d = '0;
                        wave_d    = ~wave_q;
                    end else begin
                        per_cnt_d = per_cnt_q + 11'd1;
                    end
                    if (tick_en) begin
                        dur_cnt_d = dur_cnt_q - DUR_W'(1);
                        if (dur_cnt_q == DUR_W'(1)) state_d = NEXT;
                    end
                end
            end
            NEXT: begin
                if (step_idx_q < last_q) begin
                    step_idx_d = step_idx_q + AW'(1);
                    state_d    = LOAD;
                end else if (loop) begin
                    step_idx_d = '0;
                    state_d    = LOAD;
                end else begin
                    done_d  = 1'b1;
                    wave_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything; code_out deliberately keeps its last value
        if (stop && state_q != IDLE) begin
            state_d = IDLE;
            wave_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            step_idx_q <= '0;
            last_q     <= '0;
            code_q     <= '0;
            wave_q     <= 1'b0;
            done_q     <= 1'b0;
            dur_cnt_q  <= '0;
            per_cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                code_mem_q[i] <= '0;
                dur_mem_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            step_idx_q <= step_idx_d;
            last_q     <= last_d;
            code_q     <= code_d;
            wave_q     <= wave_d;
            done_q     <= done_d;
            dur_cnt_q  <= dur_cnt_d;
            per_cnt_q  <= per_cnt_d;
            code_mem_q <= code_mem_d;
            dur_mem_q  <= dur_mem_d;
        end
    end

    assign code_out = code_q;
    assign wave     = wave_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign step_idx = step_idx_q;

endmodule
